// File: rtl/event_arb_pkg.sv
// Shared types and constants for the input-event arbiter: state encoding,
// source codes and default field widths.
package event_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPend = 2'd1,
        StHold = 2'd2
    } state_e;

    localparam logic SRC_MOUSE = 1'b0;
    localparam logic SRC_KEY   = 1'b1;

    localparam int unsigned COORD_W_DEF = 12;
    localparam int unsigned BTN_W_DEF   = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant between the mouse and keyboard requesters.
// Purely combinational; the parent owns the last-grant register.
module rr_arb2
    import event_arb_pkg::*;
(
    input  logic m_req,
    input  logic k_req,
    input  logic last_grant,
    output logic m_gnt,
    output logic k_gnt
);

    // On a tie, the requester that was not served last wins.
    always_comb begin
        m_gnt = m_req && (!k_req || (last_grant == SRC_KEY));
        k_gnt = k_req && (!m_req || (last_grant == SRC_MOUSE));
    end

endmodule

// File: rtl/event_irq_arbiter.sv
// Shares one event register set plus interrupt between mouse and keyboard decoders.
// Define EVT_MOUSE_COALESCE_EN to let matching mouse moves update a pending mouse event.
module event_irq_arbiter
    import event_arb_pkg::*;
#(
    parameter int unsigned COORD_W     = COORD_W_DEF,
    parameter int unsigned BTN_W       = BTN_W_DEF,
    parameter int unsigned ACK_TIMEOUT = 1000000,
    parameter int unsigned DROP_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               m_valid_i,
    input  logic [COORD_W-1:0] m_x_i,
    input  logic [COORD_W-1:0] m_y_i,
    input  logic [BTN_W-1:0]   m_btn_i,
    output logic               m_ready_o,
    input  logic               k_valid_i,
    input  logic [BTN_W-1:0]   k_btn_i,
    output logic               k_ready_o,
    output logic               evt_src_o,
    output logic [COORD_W-1:0] evt_x_o,
    output logic [COORD_W-1:0] evt_y_o,
    output logic [BTN_W-1:0]   evt_btn_o,
    output logic               irq_o,
    input  logic               irq_ack_i,
    output logic [DROP_W-1:0]  drop_cnt_o
);

    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                evt_src_q, evt_src_d;
    logic [COORD_W-1:0]  evt_x_q, evt_x_d;
    logic [COORD_W-1:0]  evt_y_q, evt_y_d;
    logic [BTN_W-1:0]    evt_btn_q, evt_btn_d;
    logic                m_gnt, k_gnt;
    logic                coal_ok;

    rr_arb2 u_rr_arb2 (
        .m_req      (m_valid_i),
        .k_req      (k_valid_i),
        .last_grant (last_grant_q),
        .m_gnt      (m_gnt),
        .k_gnt      (k_gnt)
    );

`ifdef EVT_MOUSE_COALESCE_EN
    // An ack in the same cycle takes precedence, so the merge is refused.
    assign coal_ok = (state_q == StPend) && (evt_src_q == SRC_MOUSE) && m_valid_i &&
                     (m_btn_i == evt_btn_q) && !irq_ack_i;
`else
    assign coal_ok = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tmr_d        = tmr_q;
        drop_d       = drop_q;
        evt_src_d    = evt_src_q;
        evt_x_d      = evt_x_q;
        evt_y_d      = evt_y_q;
        evt_btn_d    = evt_btn_q;
        m_ready_o    = 1'b0;
        k_ready_o    = 1'b0;
        irq_o        = 1'b0;

        unique case (state_q)
            StIdle: begin
                m_ready_o = m_gnt;
                k_ready_o = k_gnt;
                tmr_d     = '0;
                if (m_gnt) begin
                    evt_src_d    = SRC_MOUSE;
                    evt_x_d      = m_x_i;
                    evt_y_d      = m_y_i;
                    evt_btn_d    = m_btn_i;
                    last_grant_d = SRC_MOUSE;
                    state_d      = StPend;
                end else if (k_gnt) begin
                    evt_src_d    = SRC_KEY;
                    evt_x_d      = '0;
                    evt_y_d      = '0;
                    evt_btn_d    = k_btn_i;
                    last_grant_d = SRC_KEY;
                    state_d      = StPend;
                end
            end
            StPend: begin
                irq_o     = 1'b1;
                m_ready_o = coal_ok;
                tmr_d     = tmr_q + TMR_W'(1);
                if (irq_ack_i) begin
                    state_d = StHold;
                end else if (coal_ok) begin
                    evt_x_d = m_x_i;
                    evt_y_d = m_y_i;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_LAST) begin
                    if (drop_q != {DROP_W{1'b1}}) begin
                        drop_d = drop_q + DROP_W'(1);
                    end
                    state_d = StHold;
                end
            end
            StHold: begin
                tmr_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= SRC_KEY;
            tmr_q        <= '0;
            drop_q       <= '0;
            evt_src_q    <= 1'b0;
            evt_x_q      <= '0;
            evt_y_q      <= '0;
            evt_btn_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tmr_q        <= tmr_d;
            drop_q       <= drop_d;
            evt_src_q    <= evt_src_d;
            evt_x_q      <= evt_x_d;
            evt_y_q      <= evt_y_d;
            evt_btn_q    <= evt_btn_d;
        end
    end

    assign evt_src_o  = evt_src_q;
    assign evt_x_o    = evt_x_q;
    assign evt_y_o    = evt_y_q;
    assign evt_btn_o  = evt_btn_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_event_irq_arbiter.sv
// Scoreboard bench for event_irq_arbiter: expected events are queued by the
// stimulus and checked by a monitor on each rising edge of irq_o.
module tb_event_irq_arbiter;
    import event_arb_pkg::*;

    localparam int unsigned CW = 12;
    localparam int unsigned BW = 8;
    localparam int unsigned TO = 8;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic          src;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [BW-1:0] btn;
    } evt_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m_valid_i = 1'b0;
    logic [CW-1:0] m_x_i = '0;
    logic [CW-1:0] m_y_i = '0;
    logic [BW-1:0] m_btn_i = '0;
    logic          m_ready_o;
    logic          k_valid_i = 1'b0;
    logic [BW-1:0] k_btn_i = '0;
    logic          k_ready_o;
    logic          evt_src_o;
    logic [CW-1:0] evt_x_o;
    logic [CW-1:0] evt_y_o;
    logic [BW-1:0] evt_btn_o;
    logic          irq_o;
    logic          irq_ack_i = 1'b0;
    logic [DW-1:0] drop_cnt_o;

    int   checks = 0;
    int   errors = 0;
    evt_t exp_q[$];
    evt_t mon_act;
    evt_t mon_exp;
    logic irq_prev = 1'b0;

    event_irq_arbiter #(
        .COORD_W     (CW),
        .BTN_W       (BW),
        .ACK_TIMEOUT (TO),
        .DROP_W      (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_valid_i  (m_valid_i),
        .m_x_i      (m_x_i),
        .m_y_i      (m_y_i),
        .m_btn_i    (m_btn_i),
        .m_ready_o  (m_ready_o),
        .k_valid_i  (k_valid_i),
        .k_btn_i    (k_btn_i),
        .k_ready_o  (k_ready_o),
        .evt_src_o  (evt_src_o),
        .evt_x_o    (evt_x_o),
        .evt_y_o    (evt_y_o),
        .evt_btn_o  (evt_btn_o),
        .irq_o      (irq_o),
        .irq_ack_i  (irq_ack_i),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic evt_t mk(input logic src, input int x, input int y, input int btn);
        evt_t e;
        e.src = src;
        e.x   = CW'(x);
        e.y   = CW'(y);
        e.btn = BW'(btn);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic ack_pulse();
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
    endtask

    // Monitor: every new interrupt must present the oldest queued event.
    always @(negedge clk) begin
        if (irq_o && !irq_prev) begin
            mon_act = {evt_src_o, evt_x_o, evt_y_o, evt_btn_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got %0h expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL evt_fields: got src=%0d x=%0d y=%0d btn=%0h expected src=%0d x=%0d y=%0d btn=%0h",
                             mon_act.src, mon_act.x, mon_act.y, mon_act.btn,
                             mon_exp.src, mon_exp.x, mon_exp.y, mon_exp.btn);
                end
            end
        end
        irq_prev = irq_o;
    end

    initial begin
        int  cnt;
        logic got;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq", irq_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        chk("rst_evt", {evt_src_o, evt_x_o, evt_y_o, evt_btn_o}, 0);
        chk("rst_ready", {m_ready_o, k_ready_o}, 0);
        rst_n = 1'b1;
        step();

        // Mouse only
        m_valid_i = 1'b1; m_x_i = 100; m_y_i = 200; m_btn_i = 8'h01;
        exp_q.push_back(mk(SRC_MOUSE, 100, 200, 8'h01));
        at_neg();
        chk("mouse_only_ready", {m_ready_o, k_ready_o}, 2'b10);
        step();
        m_valid_i = 1'b0;
        at_neg();
        chk("mouse_irq_n1", irq_o, 1);

        // Pending: nothing accepted, ack gives irq low at A+1 and ready at A+2
        k_valid_i = 1'b1; k_btn_i = 8'h1C;
        m_valid_i = 1'b1; m_btn_i = 8'h02;
        at_neg();
        chk("pend_ready_low", {m_ready_o, k_ready_o}, 2'b00);
        m_valid_i = 1'b0;
        step();
        ack_pulse();
        at_neg();
        chk("ack_irq_low", irq_o, 0);
        chk("hold_ready_low", k_ready_o, 0);
        exp_q.push_back(mk(SRC_KEY, 0, 0, 8'h1C));
        at_neg();
        chk("idle_ready_a2", k_ready_o, 1);
        step();
        k_valid_i = 1'b0;
        at_neg();
        chk("key_irq", irq_o, 1);
        step();
        ack_pulse();
        step();

        // Both valid after reset: mouse first, then keyboard by round robin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        m_valid_i = 1'b1; m_x_i = 7; m_y_i = 9; m_btn_i = 8'h03;
        k_valid_i = 1'b1; k_btn_i = 8'h1C;
        exp_q.push_back(mk(SRC_MOUSE, 7, 9, 8'h03));
        at_neg();
        chk("tie_first_mouse", {m_ready_o, k_ready_o}, 2'b10);
        step();
        m_btn_i = 8'h04;
        exp_q.push_back(mk(SRC_KEY, 0, 0, 8'h1C));
        ack_pulse();
        step();
        at_neg();
        chk("tie_then_key", {m_ready_o, k_ready_o}, 2'b01);
        step();
        m_valid_i = 1'b0; k_valid_i = 1'b0;
        at_neg();
        chk("key_src", evt_src_o, SRC_KEY);
        step();
        ack_pulse();
        step();

        // Timeout: irq high for exactly TO cycles, one drop
        chk("drop_before", drop_cnt_o, 0);
        m_valid_i = 1'b1; m_x_i = 300; m_y_i = 400; m_btn_i = 8'h10;
        exp_q.push_back(mk(SRC_MOUSE, 300, 400, 8'h10));
        step();
        m_valid_i = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            at_neg();
            if (irq_o) cnt++;
            else if (cnt > 0) break;
        end
        chk("irq_high_cycles", cnt, TO);
        chk("drop_one", drop_cnt_o, 1);

        // Ack lands in the expiry cycle: ack wins, no drop
        step();
        m_valid_i = 1'b1; m_x_i = 1; m_y_i = 2; m_btn_i = 8'h20;
        exp_q.push_back(mk(SRC_MOUSE, 1, 2, 8'h20));
        step();
        m_valid_i = 1'b0;
        repeat (TO - 1) step();
        ack_pulse();
        at_neg();
        chk("ack_at_expiry_irq", irq_o, 0);
        chk("ack_at_expiry_drop", drop_cnt_o, 1);

        // 299 more timeouts: counter saturates
        k_valid_i = 1'b1; k_btn_i = 8'h1C;
        for (int i = 0; i < 299; i++) begin
            got = 1'b0;
            for (int w = 0; w < 20 && !got; w++) begin
                at_neg();
                if (k_ready_o) got = 1'b1;
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL sat_wait_ready: got no ready expected ready within 20 cycles");
                break;
            end
            exp_q.push_back(mk(SRC_KEY, 0, 0, 8'h1C));
            @(posedge clk);
            got = 1'b0;
            for (int w = 0; w < 20 && !got; w++) begin
                at_neg();
                if (!irq_o) got = 1'b1;
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL sat_wait_drop: got irq stuck high expected low within 20 cycles");
                break;
            end
        end
        k_valid_i = 1'b0;
        chk("drop_saturated", drop_cnt_o, 255);
        step();

        // Asynchronous reset while pending
        m_valid_i = 1'b1; m_x_i = 11; m_y_i = 22; m_btn_i = 8'h05;
        @(posedge clk);
        #1;
        m_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_irq", irq_o, 0);
        chk("async_rst_evt", {evt_src_o, evt_x_o, evt_y_o, evt_btn_o}, 0);
        chk("async_rst_drop", drop_cnt_o, 0);
        step();
        rst_n = 1'b1;
        step();

`ifdef EVT_MOUSE_COALESCE_EN
        m_valid_i = 1'b1; m_x_i = 1; m_y_i = 1; m_btn_i = 8'h01;
        exp_q.push_back(mk(SRC_MOUSE, 1, 1, 8'h01));
        step();
        m_x_i = 5; m_y_i = 6;
        at_neg();
        chk("coal_ready", m_ready_o, 1);
        @(posedge clk);
        #1;
        m_valid_i = 1'b0;
        at_neg();
        chk("coal_xy", {evt_x_o, evt_y_o}, {12'd5, 12'd6});
        chk("coal_irq", irq_o, 1);
        m_valid_i = 1'b1; m_x_i = 9; m_btn_i = 8'h02;
        at_neg();
        chk("coal_btn_mismatch", m_ready_o, 0);
        m_valid_i = 1'b0;
        step();
        ack_pulse();
        step();
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
